vga_timing: RTL and testbench
=============================

# vga_timing

Free-running VGA raster timing generator for the 25 MHz pixel clock domain. It produces active-low horizontal and vertical sync, the h_display/v_display active-region flags, and the current pixel coordinates. It sits directly upstream of the colour output mux: h_display AND v_display form the mux's select input, and x/y drive the pixel-colour source. An optional colour-bar generator can drive the mux's 2-bit R/G/B inputs directly for bring-up.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  pixel clock, 25 MHz, rising edge
- rst_n  in  1  asynchronous active-low reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- h_display  out  1  high while the horizontal count is in the active region
- v_display  out  1  high while the vertical count is in the active region
- x  out  10  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse when (x, y) = (0, 0)
- tp_r, tp_g, tp_b  out  2 each  test-pattern colour codes (see Configuration)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default). Both must be ≤ 1024; the 10-bit widths are fixed.
- Horizontal counter: increments every clk. At H_TOTAL-1 it wraps to 0, and that same edge advances the vertical counter.
- Vertical counter: at V_TOTAL-1, the line wrap sets it to 0.
- Decodes, all derived from the current count:
  - h_display = (x < H_ACTIVE)
  - v_display = (y < V_ACTIVE)
  - hsync = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491)
  - frame_start = (x == 0 && y == 0)
- All outputs are registers, computed from the next-state counts. No output is combinational from the counters.
- Reset puts the counters at the last pixel of the frame: x = H_TOTAL-1 (799), y = V_TOTAL-1 (524).
- Reset values of the other outputs are consistent with that position: hsync = 1, vsync = 1, h_display = 0, v_display = 0, frame_start = 0, tp_* = 0.
- Reset assertion mid-frame takes effect immediately, asynchronously. Release resumes with the next frame.

## Timing
- Every output reflects the current (x, y) in the same cycle, with no skew between sync, display flags and coordinates. Downstream consumers therefore add exactly their own latency.
- First rising edge after rst_n deasserts:
  - (x, y) = (0, 0)
  - frame_start = 1
  - h_display = v_display = 1
- frame_start is high for exactly one cycle per V_TOTAL×H_TOTAL cycles (420 000 by default).
- hsync is low for H_SYNC consecutive cycles once per line.
- vsync is low for V_SYNC×H_TOTAL consecutive cycles. It changes only on the edge where x becomes 0.
- Line wrap and frame wrap coincide on the edge from (799, 524) to (0, 0). Both counters update on that same edge.

## Configuration
- VGA_TESTPATTERN_EN defined:
  - tp_r/tp_g/tp_b carry 8 vertical colour bars, each H_ACTIVE/8 pixels wide (80 by default).
  - For bar index b = 0..7: tp_r = {b[2], b[2]}, tp_g = {b[1], b[1]}, tp_b = {b[0], b[0]}. Bar 0 is black and bar 7 is white.
  - All tp_* are 0 whenever h_display & v_display = 0.
  - The bar index is generated by a bar-width counter, not a divider, and is registered in the same cycle alignment as x.
- VGA_TESTPATTERN_EN undefined: tp_r/tp_g/tp_b are tied to 2'b00 and no bar logic is synthesised. The port list is identical in both builds.

## Test plan
- Reset then release -> at the first edge, x = 0, y = 0, frame_start = 1, hsync = vsync = 1, h_display = v_display = 1; during reset, x = 799, y = 524, all flags in their reset values.
- Run one full line -> h_display high for exactly 640 cycles; hsync low from x = 656 through x = 751 (96 cycles); y increments exactly on the x: 799→0 edge.
- Run two full frames -> frame_start pulses are exactly 420 000 cycles apart; vsync low only while y = 490..491 (1600 cycles); v_display low from y = 480 through y = 524.
- Assert rst_n low at (x, y) = (300, 200), hold 5 cycles, release -> outputs take reset values without waiting for a clock; the frame restarts at (0, 0) on the first edge.
- VGA_TESTPATTERN_EN build, line y = 10 -> tp = (0,0,0) for x = 0..79; (0,0,3) for x = 80..159; (3,3,3) for x = 560..639; (0,0,0) for x ≥ 640.
- Build without the macro -> tp_r/tp_g/tp_b are 0 for an entire frame.

Source files
------------

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Free-running VGA raster timing generator for the pixel clock domain.
// Two counters (x, y) walk the full raster. Every output is a register
// loaded from the *next* counter values, so all outputs describe the same
// (x, y) in the same cycle and none of them is a combinational decode.
//
// Reset parks the raster on the last pixel of the frame (H_TOTAL-1,
// V_TOTAL-1). The first edge after release therefore lands on (0, 0) and
// raises frame_start.
//
// Optional feature macro: VGA_TESTPATTERN_EN
//   defined   : tp_r/tp_g/tp_b carry 8 vertical colour bars across the active
//               region. The bar index comes from a bar-width counter, not a
//               divider.
//   undefined : tp_r/tp_g/tp_b are tied to 0 and no bar logic exists.
//
// Ports
//   clk          pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   h_display    x inside the visible part of the line
//   v_display    y inside the visible part of the frame
//   x, y         current pixel coordinates (10 bits each)
//   frame_start  one-cycle pulse at (0, 0)
//   tp_r/g/b     2-bit test-pattern colour codes
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       h_display,
  output logic       v_display,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic [1:0] tp_r,
  output logic [1:0] tp_g,
  output logic [1:0] tp_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit copies of the decode thresholds so every compare is width-matched.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       hsync_reg, hsync_next;
  logic       vsync_reg, vsync_next;
  logic       h_disp_reg, h_disp_next;
  logic       v_disp_reg, v_disp_next;
  logic       fs_reg, fs_next;

  // Next raster position: line wrap and frame wrap share the same edge.
  always_comb begin
    x_next = x_reg + 10'd1;
    y_next = y_reg;
    if (x_reg == H_LAST) begin
      x_next = '0;
      if (y_reg == V_LAST) begin
        y_next = '0;
      end else begin
        y_next = y_reg + 10'd1;
      end
    end
  end

  // Decodes of the next position; registered below so they line up with x/y.
  always_comb begin
    h_disp_next = (x_next < H_ACT);
    v_disp_next = (y_next < V_ACT);
    hsync_next  = !((x_next >= H_SYNC_START) && (x_next < H_SYNC_END));
    vsync_next  = !((y_next >= V_SYNC_START) && (y_next < V_SYNC_END));
    fs_next     = (x_next == '0) && (y_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= H_LAST;
      y_reg      <= V_LAST;
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      h_disp_reg <= 1'b0;
      v_disp_reg <= 1'b0;
      fs_reg     <= 1'b0;
    end else begin
      x_reg      <= x_next;
      y_reg      <= y_next;
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
      h_disp_reg <= h_disp_next;
      v_disp_reg <= v_disp_next;
      fs_reg     <= fs_next;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign h_display   = h_disp_reg;
  assign v_display   = v_disp_reg;
  assign frame_start = fs_reg;

`ifdef VGA_TESTPATTERN_EN
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

  logic [9:0] bar_cnt_reg, bar_cnt_next;
  logic [2:0] bar_idx_reg, bar_idx_next;
  logic [2:0] tp_bits_reg, tp_bits_next;

  // Bar counter tracks x: restarts with each line, steps the bar index every
  // BAR_LAST+1 pixels. Past the active region the index wraps but is masked.
  always_comb begin
    bar_cnt_next = bar_cnt_reg + 10'd1;
    bar_idx_next = bar_idx_reg;
    if (x_next == '0) begin
      bar_cnt_next = '0;
      bar_idx_next = '0;
    end else if (bar_cnt_reg == BAR_LAST) begin
      bar_cnt_next = '0;
      bar_idx_next = bar_idx_reg + 3'd1;
    end
    tp_bits_next = (h_disp_next && v_disp_next) ? bar_idx_next : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
      tp_bits_reg <= '0;
    end else begin
      bar_cnt_reg <= bar_cnt_next;
      bar_idx_reg <= bar_idx_next;
      tp_bits_reg <= tp_bits_next;
    end
  end

  // Each colour channel is one index bit replicated to 2 bits.
  for (genvar gi = 0; gi < 2; gi++) begin : g_tp_bits
    assign tp_r[gi] = tp_bits_reg[2];
    assign tp_g[gi] = tp_bits_reg[1];
    assign tp_b[gi] = tp_bits_reg[0];
  end
`else
  assign tp_r = 2'b00;
  assign tp_g = 2'b00;
  assign tp_b = 2'b00;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Two instances share clock and reset: a shrunken raster (80 x 55) that is
// run through full frames, and a default 640x480 raster that is checked
// cycle by cycle over its first lines. A reference raster model pushes the
// expected output vector for each instance on every rising edge; the vectors
// are popped and compared against the DUT on the falling edge. Run-length
// checks on the small raster measure sync widths, display widths and frame
// period from the DUT outputs themselves.
// -----------------------------------------------------------------------------
module tb_vga_timing;

  // Small raster
  localparam int S_HA = 64, S_HFP = 4, S_HS = 8, S_HBP = 4;
  localparam int S_VA = 48, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;  // 80
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;  // 55
  // Default raster
  localparam int D_HA = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int D_VA = 480, D_VFP = 10, D_VS = 2, D_VBP = 33;
  localparam int D_HT = 800, D_VT = 525;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       hd;
    logic       vd;
    logic       fs;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #20 clk = ~clk;

  logic       s_hsync, s_vsync, s_hd, s_vd, s_fs;
  logic [9:0] s_x, s_y;
  logic [1:0] s_r, s_g, s_b;
  logic       d_hsync, d_vsync, d_hd, d_vd, d_fs;
  logic [9:0] d_x, d_y;
  logic [1:0] d_r, d_g, d_b;

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .hsync(s_hsync), .vsync(s_vsync),
    .h_display(s_hd), .v_display(s_vd), .x(s_x), .y(s_y),
    .frame_start(s_fs), .tp_r(s_r), .tp_g(s_g), .tp_b(s_b)
  );

  vga_timing u_dflt (
    .clk(clk), .rst_n(rst_n), .hsync(d_hsync), .vsync(d_vsync),
    .h_display(d_hd), .v_display(d_vd), .x(d_x), .y(d_y),
    .frame_start(d_fs), .tp_r(d_r), .tp_g(d_g), .tp_b(d_b)
  );

  int tests = 0;
  int fails = 0;
  obs_t exp_q[$];
  int mx[2];
  int my[2];

  // Tracking of run lengths on the small raster
  int cyc = 0, hs_run = 0, hd_run = 0, vs_run = 0, last_fs = -1, fs_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int htot(input int i);
    return (i == 0) ? S_HT : D_HT;
  endfunction

  function automatic int vtot(input int i);
    return (i == 0) ? S_VT : D_VT;
  endfunction

  function automatic obs_t read_dut(input int i);
    obs_t o;
    if (i == 0) o = '{s_x, s_y, s_hsync, s_vsync, s_hd, s_vd, s_fs, s_r, s_g, s_b};
    else        o = '{d_x, d_y, d_hsync, d_vsync, d_hd, d_vd, d_fs, d_r, d_g, d_b};
    return o;
  endfunction

  // Expected outputs at raster position (px, py), straight from the timing table.
  function automatic obs_t expect_obs(input int i, input int px, input int py);
    obs_t o;
    int ha, hfp, hsw, va, vfp, vsw;
    if (i == 0) begin
      ha = S_HA; hfp = S_HFP; hsw = S_HS; va = S_VA; vfp = S_VFP; vsw = S_VS;
    end else begin
      ha = D_HA; hfp = D_HFP; hsw = D_HS; va = D_VA; vfp = D_VFP; vsw = D_VS;
    end
    o    = '0;
    o.x  = px[9:0];
    o.y  = py[9:0];
    o.hd = (px < ha);
    o.vd = (py < va);
    o.hs = !((px >= ha + hfp) && (px < ha + hfp + hsw));
    o.vs = !((py >= va + vfp) && (py < va + vfp + vsw));
    o.fs = (px == 0) && (py == 0);
`ifdef VGA_TESTPATTERN_EN
    begin
      logic [2:0] bar;
      bar = 3'(px / (ha / 8));
      if (o.hd && o.vd) begin
        o.r = {bar[2], bar[2]};
        o.g = {bar[1], bar[1]};
        o.b = {bar[0], bar[0]};
      end
    end
`endif
    return o;
  endfunction

  task automatic clear_tracking();
    hs_run = 0; hd_run = 0; vs_run = 0; last_fs = -1;
  endtask

  // One clock: model advances on the rising edge and pushes the expectation,
  // the DUT is compared on the falling edge.
  task automatic step();
    obs_t e, o;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mx[i] = htot(i) - 1;
        my[i] = vtot(i) - 1;
      end else if (mx[i] == htot(i) - 1) begin
        mx[i] = 0;
        my[i] = (my[i] == vtot(i) - 1) ? 0 : my[i] + 1;
      end else begin
        mx[i] = mx[i] + 1;
      end
      exp_q.push_back(expect_obs(i, mx[i], my[i]));
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      check((i == 0) ? "small_cycle" : "dflt_cycle", 64'(read_dut(i)), 64'(e));
    end
    if (!rst_n) begin
      clear_tracking();
    end else begin
      cyc++;
      o = read_dut(0);
      if (!o.hs) hs_run++;
      else begin
        if (hs_run > 0) check("hsync_low_len", 64'(hs_run), 64'(S_HS));
        hs_run = 0;
      end
      if (o.hd) hd_run++;
      else begin
        if (hd_run > 0) check("hdisp_high_len", 64'(hd_run), 64'(S_HA));
        hd_run = 0;
      end
      if (!o.vs) vs_run++;
      else begin
        if (vs_run > 0) check("vsync_low_len", 64'(vs_run), 64'(S_VS * S_HT));
        vs_run = 0;
      end
      if (o.fs) begin
        fs_cnt++;
        if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(S_HT * S_VT));
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    bit found;

    // Reset asserted between edges: outputs must settle without a clock.
    #5 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      mx[i] = htot(i) - 1;
      my[i] = vtot(i) - 1;
      check("reset_async_init", 64'(read_dut(i)), 64'(expect_obs(i, mx[i], my[i])));
    end
    repeat (3) step();
    $display("[TB] reset held: small (%0d,%0d) dflt (%0d,%0d)", s_x, s_y, d_x, d_y);

    // Release and run two full small frames plus a few cycles.
    rst_n = 1'b1;
    step();
    check("first_edge_fs", 64'(s_fs), 64'd1);
    check("first_edge_dflt_xy", {44'd0, d_x, d_y}, 64'd0);
    $display("[TB] released: small (%0d,%0d) fs=%0d", s_x, s_y, s_fs);
    repeat (2 * S_HT * S_VT + 19) step();
    check("frame_pulse_count", 64'(fs_cnt), 64'd3);
    $display("[TB] two frames done: %0d frame pulses, cycle %0d", fs_cnt, cyc);

    // Walk the small raster to (30, 20), then drop reset mid-frame.
    found = 1'b0;
    for (int k = 0; k < S_HT * S_VT && !found; k++) begin
      step();
      if (mx[0] == 30 && my[0] == 20) found = 1'b1;
    end
    check("seek_30_20", 64'(found), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    clear_tracking();
    for (int i = 0; i < 2; i++) begin
      mx[i] = htot(i) - 1;
      my[i] = vtot(i) - 1;
      check("reset_async_mid", 64'(read_dut(i)), 64'(expect_obs(i, mx[i], my[i])));
    end
    $display("[TB] mid-frame reset: small (%0d,%0d)", s_x, s_y);
    @(negedge clk);
    repeat (5) step();
    rst_n = 1'b1;
    step();
    check("restart_xy", {44'd0, s_x, s_y}, 64'd0);
    check("restart_fs", 64'(s_fs), 64'd1);
    $display("[TB] restart: small (%0d,%0d) fs=%0d", s_x, s_y, s_fs);
    repeat (3 * S_HT) step();
    $display("[TB] post-restart lines done at small (%0d,%0d)", s_x, s_y);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
